// File: rtl/risc_toy_pkg.sv
// Shared RISC_TOY definitions: datapath widths, opcodes and the fetch-queue entry layout.
package risc_toy_pkg;

    localparam int unsigned AW = 30;
    localparam int unsigned DW = 32;

    typedef enum logic [4:0] {
        OP_ADDI = 5'd0,
        OP_ANDI = 5'd1,
        OP_ORI  = 5'd2,
        OP_MOVI = 5'd3,
        OP_ADD  = 5'd4,
        OP_SUB  = 5'd5,
        OP_NEG  = 5'd6,
        OP_NOT  = 5'd7,
        OP_AND  = 5'd8,
        OP_OR   = 5'd9,
        OP_XOR  = 5'd10,
        OP_LSR  = 5'd11,
        OP_ASR  = 5'd12,
        OP_SHL  = 5'd13,
        OP_ROR  = 5'd14,
        OP_BR   = 5'd15,
        OP_BRL  = 5'd16,
        OP_J    = 5'd17,
        OP_JL   = 5'd18,
        OP_LD   = 5'd19,
        OP_LDR  = 5'd20,
        OP_ST   = 5'd21,
        OP_STR  = 5'd22
    } opcode_t;

    // One buffered fetch: instruction word plus the word address it came from.
    typedef struct packed {
        logic [DW-1:0] instr;
        logic [AW-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/risc_toy_ifetch_if.sv
// Fetch-unit bus: instruction-memory port, execute redirect and decode handshake.
interface risc_toy_ifetch_if #(
    parameter int unsigned AW    = risc_toy_pkg::AW,
    parameter int unsigned DW    = risc_toy_pkg::DW,
    parameter int unsigned DEPTH = 4
);
    logic                     IREQ;
    logic [AW-1:0]            IADDR;
    logic [DW-1:0]            INSTR;
    logic                     REDIR_VALID;
    logic [AW-1:0]            REDIR_ADDR;
    logic                     ID_VALID;
    logic                     ID_READY;
    logic [DW-1:0]            ID_INSTR;
    logic [AW-1:0]            ID_PC;
    logic [$clog2(DEPTH):0]   QCOUNT;

    // Fetch unit side.
    modport master (
        output IREQ, IADDR, ID_VALID, ID_INSTR, ID_PC, QCOUNT,
        input  INSTR, REDIR_VALID, REDIR_ADDR, ID_READY
    );

    // Memory / execute / decode side.
    modport slave (
        input  IREQ, IADDR, ID_VALID, ID_INSTR, ID_PC, QCOUNT,
        output INSTR, REDIR_VALID, REDIR_ADDR, ID_READY
    );
endinterface

// File: rtl/risc_toy_fetch_q.sv
// Synchronous instruction FIFO with push, pop, flush and occupancy count.
module risc_toy_fetch_q #(
    parameter int unsigned W     = 62,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    input  logic                   flush,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    // Pointer/count update; flush discards both the contents and any same-cycle push.
    always_comb begin
        do_push = push && !flush;
        do_pop  = pop && (count_q != '0) && !flush;
        rd_d    = rd_q + PW'(do_pop);
        wr_d    = wr_q + PW'(do_push);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
        if (flush) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    // Storage array, no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem_q[wr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_q];
    assign count = count_q;

endmodule

// File: rtl/risc_toy_ifetch.sv
// RISC_TOY fetch front end: PC, single outstanding fetch, credit-based issue, redirect flush.
module risc_toy_ifetch #(
    parameter int unsigned      AW       = risc_toy_pkg::AW,
    parameter int unsigned      DW       = risc_toy_pkg::DW,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [AW-1:0]    RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              RST,
    risc_toy_ifetch_if.master bus
);
    localparam int unsigned CW  = $clog2(DEPTH) + 1;
    localparam int unsigned CW1 = CW + 1;
    localparam int unsigned EW  = DW + AW;

    logic [AW-1:0]  pc_q, pc_d;
    logic           inflight_q, inflight_d;
    logic [AW-1:0]  inflight_addr_q, inflight_addr_d;
    logic           ireq_c, push_c, pop_c, id_valid_c;
    logic [AW-1:0]  iaddr_c;
    logic [CW1-1:0] credit_c;
    logic [CW-1:0]  count;
    logic [EW-1:0]  head;

    // Issue decision and next PC; a redirect always issues and overrides the sequential PC.
    always_comb begin
        iaddr_c         = bus.REDIR_VALID ? bus.REDIR_ADDR : pc_q;
        credit_c        = CW1'(count) + CW1'(inflight_q);
        ireq_c          = !RST && (bus.REDIR_VALID || (credit_c < CW1'(DEPTH)));
        push_c          = inflight_q && !bus.REDIR_VALID;
        id_valid_c      = (count != '0) && !RST;
        pop_c           = id_valid_c && bus.ID_READY;
        pc_d            = pc_q;
        inflight_d      = 1'b0;
        inflight_addr_d = inflight_addr_q;
        if (ireq_c) begin
            inflight_d      = 1'b1;
            inflight_addr_d = iaddr_c;
            pc_d            = iaddr_c + AW'(1);
        end
    end

    // PC and outstanding-fetch registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q            <= RESET_PC;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
        end else begin
            pc_q            <= pc_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
        end
    end

    risc_toy_fetch_q #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fetch_q (
        .clk   (CLK),
        .rst   (RST),
        .push  (push_c),
        .din   ({bus.INSTR, inflight_addr_q}),
        .pop   (pop_c),
        .flush (bus.REDIR_VALID),
        .dout  (head),
        .count (count)
    );

    assign bus.IREQ     = ireq_c;
    assign bus.IADDR    = iaddr_c;
    assign bus.ID_VALID = id_valid_c;
    assign bus.ID_INSTR = head[EW-1 -: DW];
    assign bus.ID_PC    = head[AW-1:0];
    assign bus.QCOUNT   = count;

endmodule
